// File: rtl/aes_pkg.sv
// Shared AES definitions: block size, byte type and the sequencer state encoding.
package aes_pkg;

  // Bytes in one AES state block.
  localparam int unsigned BlockBytes = 16;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/aes_inv_sbox_rom.sv
// AES inverse S-box as a purely combinational 256-entry lookup.
//   i_byte : byte to substitute
//   o_byte : InvSBox(i_byte), same cycle
module aes_inv_sbox_rom
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  localparam byte_t InvSbox [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign o_byte = InvSbox[i_byte];

endmodule

// File: rtl/aes_inv_subbytes_seq.sv
// Byte-serial InvSubBytes: accepts a block on a valid/ready handshake, runs its NB bytes
// through one shared inverse S-box (one byte per cycle, byte 0 = MSB byte) and presents the
// reassembled result on a second valid/ready handshake.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : input handshake (in_ready high only in idle)
//   in_data              : input block, 8*NB bits
//   out_valid / out_ready: output handshake (out_valid high only in done)
//   out_data             : substituted block, zero when out_valid is low
//   busy                 : high while a block is in flight or waiting to be taken
module aes_inv_subbytes_seq
  import aes_pkg::*;
#(
  parameter int unsigned NB = BlockBytes
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [8*NB-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [8*NB-1:0] out_data,
  output logic            busy
);

  localparam int unsigned     CntW    = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NB - 1);

  state_e          r_state, w_state_d;
  logic [8*NB-1:0] r_src;
  logic [8*NB-1:0] r_res, w_res_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic [7:0]      w_src_byte;
  logic [7:0]      w_sbox_byte;
  logic            w_accept;

  // Accept depends only on registered state, so no in_valid -> in_ready path exists.
  assign w_accept = (r_state == StIdle) && in_valid;

  // Byte-select mux feeding the shared S-box.
  always_comb begin
    w_src_byte = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (r_cnt == CntW'(i)) begin
        w_src_byte = r_src[8*NB-1-8*i -: 8];
      end
    end
  end

  aes_inv_sbox_rom u_sbox (
    .i_byte (w_src_byte),
    .o_byte (w_sbox_byte)
  );

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_res_d   = r_res;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_data  = '0;
    unique case (r_state)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_d = StRun;
          w_cnt_d   = '0;
          w_res_d   = '0;
        end
      end
      StRun: begin
        busy = 1'b1;
        for (int unsigned i = 0; i < NB; i++) begin
          if (r_cnt == CntW'(i)) begin
            w_res_d[8*NB-1-8*i -: 8] = w_sbox_byte;
          end
        end
        // Leave at the last byte so the counter never wraps.
        if (r_cnt == LastCnt) begin
          w_state_d = StDone;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
      StDone: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = r_res;
        if (out_ready) begin
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_src   <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_res   <= w_res_d;
      r_cnt   <= w_cnt_d;
      if (w_accept) begin
        r_src <= in_data;
      end
    end
  end

endmodule

// File: doc/aes_inv_subbytes_seq.md
# aes_inv_subbytes_seq

Sequencer for the 8-bit-datapath AES decryption path: accepts a 128-bit state block over a valid/ready handshake, streams its 16 bytes one per cycle through a single shared inverse S-box lookup, and reassembles the substituted bytes into a 128-bit result presented on a second valid/ready handshake. It sits between the decrypt round controller and the InvShiftRows/AddRoundKey stages, replacing 16 parallel inverse S-box instances with one.

## Interface
- NB, 16, bytes per block; data width is 8*NB; legal values 2..16.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  input block offered.
- in_ready  output  1  block can be accepted; high only in IDLE.
- in_data  input  8*NB  state block; byte i = in_data[8*NB-1-8*i -: 8], so byte 0 is the MSB byte.
- out_valid  output  1  result block available; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- out_data  output  8*NB  InvSubBytes(in_data), same byte ordering.
- busy  output  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture in_data into src_reg, clear cnt to 0, and go to RUN.
- RUN: each cycle, lookup byte cnt of src_reg; write the inverse S-box result into byte cnt of res_reg; increment cnt. When cnt==NB-1 is written, go to DONE.
- DONE: out_valid=1 and out_data=res_reg. On out_ready, go to IDLE. out_data is held stable while out_valid&&!out_ready.
- cnt width is $clog2(NB). It never wraps past NB-1 because the FSM leaves RUN at that value.
- in_data changes after the handshake have no effect. in_valid in RUN or DONE is ignored because in_ready is 0.
- The S-box is a pure combinational lookup with no latency. Every byte value 0x00..0xFF is legal.
- Reset values: in_ready=1 (in IDLE), out_valid=0, busy=0, out_data=0, src_reg=0, res_reg=0, cnt=0.
- rst asserted in any state (including mid-RUN or in DONE while stalled) returns to IDLE on that edge. The block in flight is discarded and all registers are cleared.
- res_reg is cleared on every new input handshake, so stale bytes never appear in out_data.

## Timing
- Input handshake at edge E0.
- Bytes 0..NB-1 are written at edges E1..E_NB.
- out_valid is high starting the cycle after E_NB; latency from accept to out_valid is NB cycles (16 at default).
- With out_ready held high:
  - DONE lasts 1 cycle.
  - IDLE lasts 1 cycle.
  - Back-to-back blocks are accepted every NB+2 cycles (18 at default).
- in_ready and out_valid are registered-state decodes with no combinational path from in_valid or out_ready.
- Backpressure: each cycle out_ready is low extends DONE by exactly one cycle. Nothing is lost or recomputed.

## Structure
- Shared package aes_pkg holds:
  - the state enum typedef (IDLE/RUN/DONE);
  - the byte typedef;
  - a constant for the block size in bytes (16).
- One sub-module: instantiate the existing aes_inv_sbox_rom once, fed by the src_reg byte mux at index cnt.
- The byte-select mux and the res_reg write-enable decode are local logic in this block.

## Test plan
- FIPS-197 inverse S-box check: in_data=0x000102030405060708090A0B0C0D0E0F -> out_data=0x52096AD5303 6A538BF40A39E81F3D7FB (0x52096AD53036A538BF40A39E81F3D7FB). out_valid rises exactly 16 cycles after the handshake.
- All-0x63 block -> out_data all 0x00. All-0xFF block -> all 0x7D. All-0x00 block -> all 0x52.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_data stable and out_valid high throughout, in_ready=0, and a single accept occurs when out_ready rises.
- Ignored input: hold in_valid=1 with changing in_data during RUN -> result matches the block captured at E0, and no second accept occurs until IDLE.
- Reset mid-RUN: assert rst at cnt=7 -> next cycle is IDLE with in_ready=1, out_valid=0, out_data=0. A new block 0x10..0x1F then yields 0x7CE339829B2FFF87348E4344C4DEE9CB.
- Throughput: stream 4 random blocks with out_ready=1 -> accepts are spaced 18 cycles apart, and every result matches the reference model.
